// File: rtl/pu_riscv_verilog_pkg.sv
// rtl/pu_riscv_verilog_pkg.sv - shared PU-RISCV types and constants
package pu_riscv_verilog_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } ex_state_t;

  // Canonical NOP (addi x0,x0,0), also used by ID bubble insertion
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pu_riscv_ex_collect_if.sv
// rtl/pu_riscv_ex_collect_if.sv - execution-unit results in, EX/WB register out
interface pu_riscv_ex_collect_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 64
);
  logic            wb_stall;
  logic            id_bubble;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_instr;
  logic            alu_bubble;
  logic [XLEN-1:0] alu_r;
  logic            mul_bubble;
  logic [XLEN-1:0] mul_r;
  logic            mul_stall;
  logic            div_bubble;
  logic [XLEN-1:0] div_r;
  logic            div_stall;
  logic            ex_stall;
  logic            ex_bubble;
  logic [XLEN-1:0] ex_r;
  logic [XLEN-1:0] ex_pc;
  logic [ILEN-1:0] ex_instr;
  logic            ex_err;

  modport master (
    output wb_stall, id_bubble, id_pc, id_instr,
    output alu_bubble, alu_r, mul_bubble, mul_r, mul_stall,
    output div_bubble, div_r, div_stall,
    input  ex_stall, ex_bubble, ex_r, ex_pc, ex_instr, ex_err
  );

  modport slave (
    input  wb_stall, id_bubble, id_pc, id_instr,
    input  alu_bubble, alu_r, mul_bubble, mul_r, mul_stall,
    input  div_bubble, div_r, div_stall,
    output ex_stall, ex_bubble, ex_r, ex_pc, ex_instr, ex_err
  );
endinterface

// File: rtl/pu_riscv_ex_hold.sv
// rtl/pu_riscv_ex_hold.sv - single-entry skid buffer for results arriving under writeback stall
module pu_riscv_ex_hold #(
  parameter int W = 192
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_q
);
  logic         r_vld;
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= 1'b0;
      r_q   <= '0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_q   <= i_data;
    end else if (i_drain) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_q   = r_q;
endmodule

// File: rtl/pu_riscv_ex_collect.sv
// rtl/pu_riscv_ex_collect.sv - merges ALU/MUL/DIV result strobes into the EX/WB register
module pu_riscv_ex_collect #(
  parameter int          XLEN      = 64,
  parameter int          ILEN      = 64,
  parameter logic [31:0] NOP_INSTR = pu_riscv_verilog_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rstn,
  pu_riscv_ex_collect_if.slave  bus
);
  import pu_riscv_verilog_pkg::*;

  localparam int              HW      = 2*XLEN + ILEN;
  localparam logic [ILEN-1:0] NOP_EXT = ILEN'(NOP_INSTR);

  ex_state_t       r_state;
  logic [XLEN-1:0] r_pend_pc;
  logic [ILEN-1:0] r_pend_instr;
  logic            r_ex_bubble;
  logic            r_ex_err;
  logic [XLEN-1:0] r_ex_r;
  logic [XLEN-1:0] r_ex_pc;
  logic [ILEN-1:0] r_ex_instr;

  logic            w_ex_stall;
  logic            w_any;
  logic            w_multi;
  logic [XLEN-1:0] w_sel_r;
  logic            w_hold_vld;
  logic            w_hold_load;
  logic            w_hold_drain;
  logic [HW-1:0]   w_hold_q;
  logic [XLEN-1:0] w_hq_r;
  logic [XLEN-1:0] w_hq_pc;
  logic [ILEN-1:0] w_hq_instr;

  // div > mul > alu; losers of a collision are dropped and flagged
  always_comb begin
    w_sel_r = bus.alu_r;
    if (!bus.div_bubble)      w_sel_r = bus.div_r;
    else if (!bus.mul_bubble) w_sel_r = bus.mul_r;
  end

  assign w_any   = ~(bus.div_bubble & bus.mul_bubble & bus.alu_bubble);
  assign w_multi = (~bus.div_bubble & ~bus.mul_bubble) |
                   (~bus.div_bubble & ~bus.alu_bubble) |
                   (~bus.mul_bubble & ~bus.alu_bubble);

  assign w_ex_stall   = bus.wb_stall | bus.mul_stall | bus.div_stall | w_hold_vld;
  assign w_hold_load  = (r_state == ST_RUN)  &  bus.wb_stall & w_any;
  assign w_hold_drain = (r_state == ST_HOLD) & ~bus.wb_stall;
  assign {w_hq_r, w_hq_pc, w_hq_instr} = w_hold_q;

  pu_riscv_ex_hold #(.W(HW)) u_hold (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_hold_load),
    .i_drain (w_hold_drain),
    .i_data  ({w_sel_r, r_pend_pc, r_pend_instr}),
    .o_vld   (w_hold_vld),
    .o_q     (w_hold_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_RUN;
      r_pend_pc    <= '0;
      r_pend_instr <= NOP_EXT;
      r_ex_bubble  <= 1'b1;
      r_ex_err     <= 1'b0;
      r_ex_r       <= '0;
      r_ex_pc      <= '0;
      r_ex_instr   <= NOP_EXT;
    end else begin
      // pend_* pairs a late (multi-cycle) result with the instruction that produced it
      if (!w_ex_stall && !bus.id_bubble) begin
        r_pend_pc    <= bus.id_pc;
        r_pend_instr <= bus.id_instr;
      end
      case (r_state)
        ST_RUN: begin
          r_ex_err <= w_multi;
          if (!bus.wb_stall) begin
            r_ex_pc <= r_pend_pc;
            if (w_any) begin
              r_ex_r      <= w_sel_r;
              r_ex_bubble <= 1'b0;
              r_ex_instr  <= r_pend_instr;
            end else begin
              r_ex_bubble <= 1'b1;
              r_ex_instr  <= NOP_EXT;
            end
          end else if (w_any) begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // ex_stall was high, so any strobe here is a protocol violation
          r_ex_err <= w_any;
          if (!bus.wb_stall) begin
            r_ex_r      <= w_hq_r;
            r_ex_pc     <= w_hq_pc;
            r_ex_instr  <= w_hq_instr;
            r_ex_bubble <= 1'b0;
            r_state     <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.ex_stall  = w_ex_stall;
  assign bus.ex_bubble = r_ex_bubble;
  assign bus.ex_r      = r_ex_r;
  assign bus.ex_pc     = r_ex_pc;
  assign bus.ex_instr  = r_ex_instr;
  assign bus.ex_err    = r_ex_err;
endmodule

// File: tb/tb_pu_riscv_ex_collect.sv
// tb/tb_pu_riscv_ex_collect.sv - directed self-checking bench for pu_riscv_ex_collect
module tb_pu_riscv_ex_collect;
  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  localparam logic [63:0] NOP   = 64'h13;
  localparam logic [63:0] I_ADD = 64'h0000_0000_0000_0033;
  localparam logic [63:0] I_DIV = 64'h0000_0000_02c5_4533;
  localparam logic [63:0] I_DVZ = 64'h0000_0000_02c5_c533;

  pu_riscv_ex_collect_if #(.XLEN(64), .ILEN(64)) bus ();

  pu_riscv_ex_collect #(.XLEN(64), .ILEN(64)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn           = 1'b0;
    bus.wb_stall   = 1'b0;
    bus.id_bubble  = 1'b1;
    bus.id_pc      = '0;
    bus.id_instr   = '0;
    bus.alu_bubble = 1'b1;
    bus.alu_r      = '0;
    bus.mul_bubble = 1'b1;
    bus.mul_r      = '0;
    bus.mul_stall  = 1'b0;
    bus.div_bubble = 1'b1;
    bus.div_r      = '0;
    bus.div_stall  = 1'b0;
    tick();
    tick();

    chk("rst_bubble", 64'(bus.ex_bubble), 64'd1);
    chk("rst_r",      bus.ex_r, 64'd0);
    chk("rst_pc",     bus.ex_pc, 64'd0);
    chk("rst_instr",  bus.ex_instr, NOP);
    chk("rst_err",    64'(bus.ex_err), 64'd0);
    chk("rst_stall",  64'(bus.ex_stall), 64'd0);
    chk("rst_hold",   64'(dut.w_hold_vld), 64'd0);
    rstn = 1'b1;
    tick();

    // ALU back-to-back
    bus.id_bubble = 1'b0; bus.id_pc = 64'h10; bus.id_instr = I_ADD;
    tick();
    bus.alu_bubble = 1'b0; bus.alu_r = 64'd1; bus.id_pc = 64'h14;
    tick();
    chk("alu1_r",      bus.ex_r, 64'd1);
    chk("alu1_pc",     bus.ex_pc, 64'h10);
    chk("alu1_bubble", 64'(bus.ex_bubble), 64'd0);
    bus.alu_r = 64'd2; bus.id_pc = 64'h18;
    tick();
    chk("alu2_r",  bus.ex_r, 64'd2);
    chk("alu2_pc", bus.ex_pc, 64'h14);
    bus.alu_r = 64'd3; bus.id_bubble = 1'b1;
    tick();
    chk("alu3_r",      bus.ex_r, 64'd3);
    chk("alu3_pc",     bus.ex_pc, 64'h18);
    chk("alu3_bubble", 64'(bus.ex_bubble), 64'd0);
    chk("alu3_err",    64'(bus.ex_err), 64'd0);
    bus.alu_bubble = 1'b1;
    tick();
    chk("idle_bubble", 64'(bus.ex_bubble), 64'd1);
    chk("idle_instr",  bus.ex_instr, NOP);
    chk("idle_r_kept", bus.ex_r, 64'd3);

    // collision: mul beats alu
    bus.alu_bubble = 1'b0; bus.alu_r = 64'd5;
    bus.mul_bubble = 1'b0; bus.mul_r = 64'd7;
    tick();
    chk("coll_r",   bus.ex_r, 64'd7);
    chk("coll_err", 64'(bus.ex_err), 64'd1);
    bus.alu_bubble = 1'b1; bus.mul_bubble = 1'b1;
    tick();
    chk("coll_err_clr", 64'(bus.ex_err), 64'd0);

    // divide-by-zero fast path
    bus.id_bubble = 1'b0; bus.id_pc = 64'h200; bus.id_instr = I_DVZ;
    tick();
    bus.id_bubble = 1'b1;
    bus.div_bubble = 1'b0; bus.div_r = '1;
    tick();
    chk("dvz_r",     bus.ex_r, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dvz_instr", bus.ex_instr, I_DVZ);
    chk("dvz_pc",    bus.ex_pc, 64'h200);
    bus.div_bubble = 1'b1;
    tick();

    // DIV result lands while writeback is stalled
    bus.id_bubble = 1'b0; bus.id_pc = 64'h100; bus.id_instr = I_DIV;
    tick();
    bus.id_bubble = 1'b1; bus.div_stall = 1'b1;
    #1;
    chk("div_busy_stall", 64'(bus.ex_stall), 64'd1);
    for (int i = 0; i < 66; i++) tick();
    bus.div_stall = 1'b0; bus.div_bubble = 1'b0;
    bus.div_r = 64'hFFFF_FFFF_FFFF_FFFD; bus.wb_stall = 1'b1;
    tick();
    bus.div_bubble = 1'b1; bus.div_r = '0;
    chk("div_hold_vld",    64'(dut.w_hold_vld), 64'd1);
    chk("div_hold_stall",  64'(bus.ex_stall), 64'd1);
    chk("div_hold_bubble", 64'(bus.ex_bubble), 64'd1);
    tick();
    tick();

    // hold overflow: strobe while hold is full
    bus.alu_bubble = 1'b0; bus.alu_r = 64'hDEAD;
    tick();
    bus.alu_bubble = 1'b1;
    chk("ovf_err", 64'(bus.ex_err), 64'd1);
    tick();
    chk("ovf_err_clr", 64'(bus.ex_err), 64'd0);
    chk("ovf_stall",   64'(bus.ex_stall), 64'd1);
    tick();
    bus.wb_stall = 1'b0;
    #1;
    chk("drain_stall_hi", 64'(bus.ex_stall), 64'd1);
    tick();
    chk("div_r",      bus.ex_r, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_pc",     bus.ex_pc, 64'h100);
    chk("div_instr",  bus.ex_instr, I_DIV);
    chk("div_bubble", 64'(bus.ex_bubble), 64'd0);
    chk("div_stall_lo", 64'(bus.ex_stall), 64'd0);

    // reset mid-hold
    bus.wb_stall = 1'b1; bus.alu_bubble = 1'b0; bus.alu_r = 64'h55;
    tick();
    bus.alu_bubble = 1'b1;
    chk("rh_hold_vld", 64'(dut.w_hold_vld), 64'd1);
    chk("rh_kept_bub", 64'(bus.ex_bubble), 64'd0);
    rstn = 1'b0;
    #1;
    chk("rh_bubble", 64'(bus.ex_bubble), 64'd1);
    chk("rh_instr",  bus.ex_instr, NOP);
    chk("rh_r",      bus.ex_r, 64'd0);
    chk("rh_hold",   64'(dut.w_hold_vld), 64'd0);
    tick();
    rstn = 1'b1; bus.wb_stall = 1'b0;
    #1;
    chk("rh_stall", 64'(bus.ex_stall), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rh_no_emit", 64'(bus.ex_bubble), 64'd1);
    end
    chk("rh_r_after", bus.ex_r, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pu_riscv_ex_collect.md
# pu_riscv_ex_collect

Execute-stage result collector for the PU-RISCV core. It is downstream of the ALU, multiplier and divider. It merges their one-cycle result strobes (`*_bubble` low) into a single registered execute→writeback pipeline register. A one-entry hold buffer keeps multi-cycle results, such as a divider result pulse, from being lost while writeback stalls. It also generates the global `ex_stall` that freezes the issue side and the execution units.

## Interface
- `XLEN`, 64, datapath width
- `ILEN`, 64, instruction register width
- `NOP_INSTR`, 32'h0000_0013, instruction value reported for bubbles
- `rstn`  in  1  reset; asynchronous, active-low
- `clk`  in  1  clock
- `wb_stall`  in  1  writeback cannot accept this cycle
- `id_bubble`  in  1  issue slot empty
- `id_pc`  in  XLEN  PC of issuing instruction
- `id_instr`  in  ILEN  issuing instruction
- `alu_bubble`, `alu_r`  in  1 / XLEN  ALU result strobe (active-low) and value
- `mul_bubble`, `mul_r`, `mul_stall`  in  1 / XLEN / 1  multiplier strobe, value, busy
- `div_bubble`, `div_r`, `div_stall`  in  1 / XLEN / 1  divider strobe, value, busy
- `ex_stall`  out  1  combinational: `wb_stall | mul_stall | div_stall | hold_vld`
- `ex_bubble`  out  1  registered; 0 means `ex_r`/`ex_pc`/`ex_instr` are valid
- `ex_r`  out  XLEN  registered result
- `ex_pc`  out  XLEN  PC belonging to `ex_r`
- `ex_instr`  out  ILEN  instruction belonging to `ex_r`
- `ex_err`  out  1  one-cycle pulse on a protocol violation

## Operation
- **Issue tracking.** When `!ex_stall && !id_bubble`, latch `id_pc`/`id_instr` into `pend_pc`/`pend_instr`. These registers hold until the next issue, so a multi-cycle result is paired with its own instruction.
- **Source select.** A unit result is present when its bubble input is low.
  - Priority is `div` > `mul` > `alu`.
  - If more than one unit strobes in the same cycle, the highest-priority result is taken, the others are dropped, and `ex_err` pulses.
- **FSM `ST_RUN`/`ST_HOLD`:**
  - **`ST_RUN`, `!wb_stall`:** the output register loads the selected result with `pend_pc`/`pend_instr`.
    - With a strobe present: `ex_bubble <= 0`.
    - With no strobe: `ex_bubble <= 1`, `ex_r` keeps its value, and `ex_instr <= NOP_INSTR`.
  - **`ST_RUN`, `wb_stall`:** output registers are unchanged.
    - A strobe arriving this cycle is written into the hold buffer (`hold_r`, `hold_pc`, `hold_instr`), `hold_vld <= 1`, next state `ST_HOLD`.
  - **`ST_HOLD`, `wb_stall`:** no change.
    - A new unit strobe is a violation (`ex_stall` was high): it is dropped and `ex_err` pulses.
  - **`ST_HOLD`, `!wb_stall`:** the output register loads the hold contents with `ex_bubble <= 0`, `hold_vld <= 0`, next state `ST_RUN`.
    - A unit strobe in this same cycle is a violation: it is dropped and `ex_err` pulses.
- **Data handling.** Data is passed through unmodified. There is no sign handling; units deliver final XLEN values.

## Timing
- Reset values:
  - `ex_bubble=1`, `ex_r=0`, `ex_pc=0`, `ex_instr=NOP_INSTR`, `ex_err=0`
  - `hold_vld=0`, state `ST_RUN`
  - `ex_stall=0` once `wb_stall`/`mul_stall`/`div_stall` are low
- Latency: the unit strobe in cycle N appears on `ex_*` in cycle N+1 when not stalled.
  - If held, it appears one cycle after the first cycle with `wb_stall` low.
- `ex_stall` has no register stage. It must rise in the same cycle `hold_vld` becomes 1, and fall in the cycle after the hold is drained.
- Divider interplay: `div_stall` and `div_bubble=0` change on the same edge. The collector must capture `div_r` in that exact cycle; it never appears again.
- Reset asserted mid-operation: hold contents are discarded, the outputs return to reset values immediately, and there is no pending result after release.
- `ex_err` is high for exactly one cycle per violating cycle.

## Structure
- Add to `pu_riscv_verilog_pkg`:
  - the `ST_RUN`/`ST_HOLD` constants;
  - `NOP_INSTR` (shared with ID bubble insertion).
- One natural sub-module, `pu_riscv_ex_hold`: the single-entry skid buffer with inputs `load`, `drain`, `data{r,pc,instr}` and outputs `vld`, `q`.
- The source priority mux and the output register stay in the top.

## Test plan
- **ALU back-to-back.** `alu_bubble=0` for 3 cycles with `alu_r=1,2,3`, `wb_stall=0` → `ex_r=1,2,3` one cycle later, `ex_bubble=0` throughout, `ex_err=0`.
- **DIV under stall.** Issue DIV (`pend_pc=0x100`). `div_stall` is high for 66 cycles, then `div_bubble=0`, `div_r=0xFFFF_FFFF_FFFF_FFFD`, while `wb_stall=1` → `hold_vld=1` and `ex_stall` stays high. Drop `wb_stall` 5 cycles later → next cycle `ex_r=0x…FFFD`, `ex_pc=0x100`, `ex_bubble=0`, and `ex_stall` falls.
- **Divide-by-zero fast path.** `div_bubble=0` one cycle after issue, with `div_r` all ones → `ex_r=64'hFFFF_FFFF_FFFF_FFFF` next cycle, paired with the DIV `ex_instr`.
- **Collision.** `alu_bubble=0` and `mul_bubble=0` in the same cycle, `alu_r=5`, `mul_r=7` → `ex_r=7`, `ex_err` pulses once.
- **Hold overflow.** Hold is full and `wb_stall=1`; inject `alu_bubble=0` → result dropped, `ex_err=1` for one cycle, the held value is delivered unchanged.
- **Reset mid-hold.** `hold_vld=1` and `rstn` pulsed low → `ex_bubble=1`, `ex_instr=0x13`, `hold_vld=0`, and no result is emitted after release.
